// File: rtl/dram_uart_pkg.sv
// Shared constants and state encodings for the UART-fed DRAM write port.
// Header byte layout: bit 7 marks a header, bit 6 is reserved (must be 0), bits 5:0 carry the address.
package dram_uart_pkg;

    localparam int DRAM_AW  = 6;
    localparam int DRAM_DW  = 8;
    localparam int HDR_MARK = 7;
    localparam int HDR_RSVD = 6;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_e;

    typedef enum logic {
        CMD_HDR = 1'b0,
        CMD_DAT = 1'b1
    } cmd_state_e;

    function automatic logic is_header(input logic [7:0] b);
        return b[HDR_MARK] & ~b[HDR_RSVD];
    endfunction

endpackage

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: 2-FF synchronizer plus a mid-bit sampling FSM.
// byte_valid/frame_err are registered single-cycle pulses issued on the stop-bit sample.
module uart_rx_8n1
    import dram_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

    logic            rx_meta_q;
    logic            rx_s_q;
    rx_state_e       state_q,      state_d;
    logic [CNT_W-1:0] clk_cnt_q,   clk_cnt_d;
    logic [2:0]      bit_cnt_q,    bit_cnt_d;
    logic [7:0]      shift_q,      shift_d;
    logic [7:0]      byte_data_q,  byte_data_d;
    logic            byte_valid_q, byte_valid_d;
    logic            frame_err_q,  frame_err_d;

    always_comb begin
        state_d      = state_q;
        clk_cnt_d    = clk_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        byte_data_d  = byte_data_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        case (state_q)
            RX_IDLE: begin
                if (!rx_s_q) begin
                    clk_cnt_d = '0;
                    bit_cnt_d = '0;
                    state_d   = RX_START;
                end
            end
            RX_START: begin
                // A start bit that is high again at mid-bit was only a glitch.
                if (clk_cnt_q == HALF_M1) begin
                    clk_cnt_d = '0;
                    state_d   = rx_s_q ? RX_IDLE : RX_DATA;
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_DATA: begin
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_STOP;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            RX_STOP: begin
                // Leaving at mid-stop-bit lets IDLE catch a back-to-back start bit.
                if (clk_cnt_q == FULL_M1) begin
                    clk_cnt_d = '0;
                    state_d   = RX_IDLE;
                    if (rx_s_q) begin
                        byte_valid_d = 1'b1;
                        byte_data_d  = shift_q;
                    end else begin
                        frame_err_d  = 1'b1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= RX_IDLE;
            clk_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_data_q  <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_meta_q    <= rx;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            clk_cnt_q    <= clk_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            byte_data_q  <= byte_data_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign frame_err  = frame_err_q;

endmodule

// File: rtl/dram_uart_writer.sv
// Decodes (header, data) byte pairs from the UART into single-cycle DRAM write strobes.
// A pending command is abandoned on a framing error or after TIMEOUT_CLKS idle cycles.
module dram_uart_writer
    import dram_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int TIMEOUT_CLKS = 1_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rx,
    output logic               we,
    output logic [DRAM_AW-1:0] waddr,
    output logic [DRAM_DW-1:0] wdata,
    output logic               busy,
    output logic               frame_err,
    output logic               hdr_err,
    output logic [7:0]         wr_count
);

    localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CLKS);

    logic       rx_byte_valid;
    logic [7:0] rx_byte_data;
    logic       rx_frame_err;

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_valid(rx_byte_valid),
        .byte_data (rx_byte_data),
        .frame_err (rx_frame_err)
    );

    cmd_state_e         state_q,    state_d;
    logic [DRAM_AW-1:0] addr_q,     addr_d;
    logic [TO_W-1:0]    idle_cnt_q, idle_cnt_d;
    logic               we_q,       we_d;
    logic [DRAM_AW-1:0] waddr_q,    waddr_d;
    logic [DRAM_DW-1:0] wdata_q,    wdata_d;
    logic               busy_q,     busy_d;
    logic               hdr_err_q,  hdr_err_d;
    logic [7:0]         wr_count_q, wr_count_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        idle_cnt_d = idle_cnt_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        busy_d     = busy_q;
        hdr_err_d  = 1'b0;
        wr_count_d = wr_count_q;
        case (state_q)
            CMD_HDR: begin
                if (rx_byte_valid) begin
                    if (is_header(rx_byte_data)) begin
                        addr_d     = rx_byte_data[DRAM_AW-1:0];
                        idle_cnt_d = '0;
                        busy_d     = 1'b1;
                        state_d    = CMD_DAT;
                    end else begin
                        hdr_err_d  = 1'b1;
                    end
                end
            end
            CMD_DAT: begin
                // A completed byte takes priority over a timeout in the same cycle.
                if (rx_byte_valid) begin
                    we_d       = 1'b1;
                    waddr_d    = addr_q;
                    wdata_d    = rx_byte_data;
                    wr_count_d = wr_count_q + 8'd1;
                    busy_d     = 1'b0;
                    state_d    = CMD_HDR;
                end else if (rx_frame_err || idle_cnt_q == TO_LIMIT) begin
                    busy_d     = 1'b0;
                    state_d    = CMD_HDR;
                end else begin
                    idle_cnt_d = idle_cnt_q + TO_W'(1);
                end
            end
            default: state_d = CMD_HDR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= CMD_HDR;
            addr_q     <= '0;
            idle_cnt_q <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            hdr_err_q  <= 1'b0;
            wr_count_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            idle_cnt_q <= idle_cnt_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            hdr_err_q  <= hdr_err_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign we        = we_q;
    assign waddr     = waddr_q;
    assign wdata     = wdata_q;
    assign busy      = busy_q;
    assign hdr_err   = hdr_err_q;
    assign wr_count  = wr_count_q;
    assign frame_err = rx_frame_err;

endmodule

// File: tb/tb_dram_uart_writer.sv
// Directed bench for dram_uart_writer: bit-banged UART stimulus with hand-computed expectations.
module tb_dram_uart_writer;

    localparam int CPB = 16;
    localparam int TO  = 2000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic       we;
    logic [5:0] waddr;
    logic [7:0] wdata;
    logic       busy;
    logic       frame_err;
    logic       hdr_err;
    logic [7:0] wr_count;

    always #5 clk = ~clk;

    dram_uart_writer #(
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_CLKS(TO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .busy     (busy),
        .frame_err(frame_err),
        .hdr_err  (hdr_err),
        .wr_count (wr_count)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int hdr_cnt  = 0;
    int fe_cnt   = 0;
    logic [13:0] wlog[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (we) begin
                we_cnt++;
                wlog.push_back({waddr, wdata});
            end
            if (hdr_err) hdr_cnt++;
            if (frame_err) fe_cnt++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_bit;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " we"},        32'(we),        32'd0);
        check({tag, " busy"},      32'(busy),      32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
        check({tag, " hdr_err"},   32'(hdr_err),   32'd0);
        check({tag, " waddr"},     32'(waddr),     32'd0);
        check({tag, " wdata"},     32'(wdata),     32'd0);
        check({tag, " wr_count"},  32'(wr_count),  32'd0);
    endtask

    typedef struct {
        logic [7:0] hdr;
        logic [7:0] dat;
        logic [5:0] exp_addr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int base, h0, f0, exp_wc;
        logic [7:0] hb, db;

        vecs[0] = '{8'h85, 8'hA5, 6'd5,  8'hA5};
        vecs[1] = '{8'h9F, 8'h00, 6'd31, 8'h00};
        vecs[2] = '{8'hBE, 8'hFF, 6'd62, 8'hFF};
        vecs[3] = '{8'hAA, 8'hC3, 6'd42, 8'hC3};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Plain commands from the vector table
        exp_wc = 0;
        for (int v = 0; v < 4; v++) begin
            base = we_cnt;
            send_byte(vecs[v].hdr, 1'b1);
            check($sformatf("vec%0d busy after hdr", v), 32'(busy), 32'd1);
            check($sformatf("vec%0d no we after hdr", v), 32'(we_cnt), 32'(base));
            send_byte(vecs[v].dat, 1'b1);
            exp_wc++;
            check($sformatf("vec%0d we count", v), 32'(we_cnt), 32'(base + 1));
            check($sformatf("vec%0d waddr", v), 32'(waddr), 32'(vecs[v].exp_addr));
            check($sformatf("vec%0d wdata", v), 32'(wdata), 32'(vecs[v].exp_data));
            check($sformatf("vec%0d wr_count", v), 32'(wr_count), 32'(exp_wc));
            check($sformatf("vec%0d busy after dat", v), 32'(busy), 32'd0);
        end

        // Rejected header, then a valid command
        h0 = hdr_cnt; base = we_cnt;
        send_byte(8'h05, 1'b1);
        check("hdr_err on 0x05", 32'(hdr_cnt), 32'(h0 + 1));
        check("busy stays low on bad hdr", 32'(busy), 32'd0);
        send_byte(8'h81, 1'b1);
        send_byte(8'h3C, 1'b1);
        check("resync we count", 32'(we_cnt), 32'(base + 1));
        check("resync waddr", 32'(waddr), 32'd1);
        check("resync wdata", 32'(wdata), 32'h3C);
        check("resync hdr_err count", 32'(hdr_cnt), 32'(h0 + 1));

        // Framing error on the data byte drops the command
        f0 = fe_cnt; h0 = hdr_cnt; base = we_cnt;
        send_byte(8'hBF, 1'b1);
        check("busy after 0xBF", 32'(busy), 32'd1);
        send_byte(8'h42, 1'b0);
        repeat (20) @(negedge clk);
        check("frame_err pulse", 32'(fe_cnt), 32'(f0 + 1));
        check("no we on frame err", 32'(we_cnt), 32'(base));
        check("busy cleared by frame err", 32'(busy), 32'd0);
        check("no hdr_err on frame err", 32'(hdr_cnt), 32'(h0));
        send_byte(8'h80, 1'b1);
        send_byte(8'h11, 1'b1);
        check("post-frame we count", 32'(we_cnt), 32'(base + 1));
        check("post-frame waddr", 32'(waddr), 32'd0);
        check("post-frame wdata", 32'(wdata), 32'h11);

        // Start-bit glitch, then a header that times out
        f0 = fe_cnt; h0 = hdr_cnt; base = we_cnt;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch no we", 32'(we_cnt), 32'(base));
        check("glitch no hdr_err", 32'(hdr_cnt), 32'(h0));
        check("glitch no frame_err", 32'(fe_cnt), 32'(f0));
        send_byte(8'h82, 1'b1);
        check("timeout busy set", 32'(busy), 32'd1);
        repeat (1800) @(negedge clk);
        check("busy before timeout", 32'(busy), 32'd1);
        repeat (300) @(negedge clk);
        check("busy after timeout", 32'(busy), 32'd0);
        check("timeout no error pulse", 32'(hdr_cnt + fe_cnt), 32'(h0 + f0));
        send_byte(8'h55, 1'b1);
        check("0x55 after timeout hdr_err", 32'(hdr_cnt), 32'(h0 + 1));
        check("0x55 after timeout no we", 32'(we_cnt), 32'(base));

        // Reset during bit 3 of a data byte
        f0 = fe_cnt; h0 = hdr_cnt; base = we_cnt;
        send_byte(8'h84, 1'b1);
        check("pre-reset busy", 32'(busy), 32'd1);
        fork
            send_byte(8'hF8, 1'b1);
            begin
                repeat (CPB * 4 + 8) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                check_reset_outputs("midbyte reset");
                rst = 1'b0;
            end
        join
        repeat (20) @(negedge clk);
        check("no we after reset", 32'(we_cnt), 32'(base));
        check("no errors after reset", 32'(hdr_cnt + fe_cnt), 32'(h0 + f0));
        send_byte(8'h8A, 1'b1);
        send_byte(8'h77, 1'b1);
        check("post-reset we count", 32'(we_cnt), 32'(base + 1));
        check("post-reset waddr", 32'(waddr), 32'd10);
        check("post-reset wdata", 32'(wdata), 32'h77);
        check("post-reset wr_count", 32'(wr_count), 32'd1);

        // 256 back-to-back writes from a clean count
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        wlog.delete();
        base = we_cnt;
        for (int i = 0; i < 256; i++) begin
            hb = 8'h80 | 8'(i % 64);
            db = 8'((i * 37 + 11) % 256);
            send_byte(hb, 1'b1);
            send_byte(db, 1'b1);
        end
        repeat (20) @(negedge clk);
        check("burst we count", 32'(we_cnt - base), 32'd256);
        check("burst wr_count wrap", 32'(wr_count), 32'd0);
        check("burst log size", 32'(wlog.size()), 32'd256);
        for (int i = 0; i < 256 && i < wlog.size(); i++) begin
            check($sformatf("burst write %0d addr/data", i), 32'(wlog[i]),
                  32'({6'(i % 64), 8'((i * 37 + 11) % 256)}));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dram_uart_writer.md
# dram_uart_writer

UART-driven write-port controller for the 64x8 distributed-RAM test design. Takes the board `rx` line after the differential clock buffer, receives 8N1 bytes and decodes two-byte (header, data) commands. Each complete command becomes a single-cycle write strobe with address and data to the 64x8 DRAM. Lets the host load the RAM over serial while switches and LEDs exercise the read side.

## Interface
Parameters:
- `CLKS_PER_BIT`, 868: clock cycles per UART bit (100 MHz / 115200). Minimum 8.
- `TIMEOUT_CLKS`, 1_000_000: maximum idle cycles allowed between header and data byte.

Ports:
- `clk`  in  1  design clock, from the differential input buffer.
- `rst`  in  1  reset; synchronous, active-high.
- `rx`  in  1  UART line, asynchronous to `clk`, idle high.
- `we`  out  1  DRAM write strobe, one-cycle pulse.
- `waddr`  out  6  DRAM write address; valid when `we`=1.
- `wdata`  out  8  DRAM write data; valid when `we`=1.
- `busy`  out  1  high while a header has been accepted and its data byte is pending.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit.
- `hdr_err`  out  1  one-cycle pulse when a header byte is rejected.
- `wr_count`  out  8  number of completed writes, modulo 256.

## Operation
- `rx` passes through a 2-FF synchronizer; the second stage is `rx_s`. Only `rx_s` is used internally.
- Receiver FSM, states IDLE, START, DATA, STOP:
  - IDLE: on `rx_s`=0, clear the bit counter and go to START.
  - START: count to `CLKS_PER_BIT/2` (integer division) to reach mid-bit. If `rx_s`=1 there, treat it as a glitch and return to IDLE with no output. Otherwise go to DATA.
  - DATA: every `CLKS_PER_BIT` cycles, sample `rx_s` into the shift register, LSB first. After 8 samples go to STOP.
  - STOP: after `CLKS_PER_BIT` cycles, sample. If 1, pulse `byte_valid` with the byte. If 0, pulse `frame_err` and discard the byte. Either way return to IDLE.
- Command FSM, states HDR, DAT:
  - HDR, on `byte_valid`:
    - bit7=1 and bit6=0: latch bits 5:0 as the address, go to DAT, `busy`=1.
    - Any other byte: pulse `hdr_err`, stay in HDR. This is how the decoder resynchronises.
  - DAT, on `byte_valid`: pulse `we` with the latched address and this byte as `wdata`, increment `wr_count`, go to HDR. Any byte value is legal data.
  - DAT, on `frame_err`: go to HDR and drop the command; no `we`.
  - DAT timeout: the idle counter reaches `TIMEOUT_CLKS` with no byte completed. Go to HDR silently, with no error pulse. The counter restarts on entry to DAT.
  - If `byte_valid` and the timeout land in the same cycle, `byte_valid` wins.
- `wr_count` wraps 255→0.
- `waddr` and `wdata` hold their last value between strobes.

## Timing
- Reset values:
  - `we`, `busy`, `frame_err`, `hdr_err` = 0.
  - `waddr` = 0, `wdata` = 0, `wr_count` = 0.
  - Both FSMs in their idle state (IDLE, HDR); synchronizer stages = 1.
- Reset asserted mid-byte or mid-command aborts it. No strobe or error pulse is issued for the aborted work.
- `rx_s` lags `rx` by 2 cycles.
- `byte_valid` fires in the cycle the stop bit is sampled. That is 9.5×`CLKS_PER_BIT` cycles (±1) after `rx_s` falls.
- `we` is registered: high exactly one cycle after the `byte_valid` of the data byte.
- `busy` rises one cycle after the header's `byte_valid` and falls together with `we`.
- All outputs are registered; there are no combinational paths from `rx`.
- Back-to-back bytes with no idle bits are accepted. IDLE sees the next start bit, since STOP leaves at mid-stop-bit.

## Structure
- Shared package `dram_uart_pkg`:
  - RAM geometry constants `DRAM_AW`=6 and `DRAM_DW`=8.
  - Header bit positions: `HDR_MARK`=7, `HDR_RSVD`=6.
  - State enums for both FSMs.
- Sub-module `uart_rx_8n1`, parameter `CLKS_PER_BIT`:
  - Contains the synchronizer and receiver FSM.
  - Outputs `byte_valid`, `byte_data`, `frame_err`.
  - The command FSM, timeout counter and write port live in `dram_uart_writer`.

## Test plan
Bench parameters: `CLKS_PER_BIT`=16, `TIMEOUT_CLKS`=2000.
- Send 0x85 then 0xA5 → one `we` pulse with `waddr`=5 and `wdata`=0xA5. `wr_count`=1. `busy` high between the two bytes.
- Send 0x05, then 0x81 and 0x3C → `hdr_err` pulses once with no `we`. Then `we` with `waddr`=1, `wdata`=0x3C.
- Send 0xBF, then 0x42 with stop bit forced to 0 → `frame_err` pulses and there is no `we`. A following 0x80, 0x11 writes `waddr`=0, `wdata`=0x11.
- Drive `rx` low for 4 cycles only → no `byte_valid` and no error. Then send 0x82, wait 2100 cycles, send 0x55 → `busy` drops at timeout, no write, and 0x55 raises `hdr_err`.
- Assert `rst` for 1 cycle during bit 3 of a data byte → every output returns to its reset value and no `we` is issued. The next full command writes correctly.
- Issue 256 writes to addresses 0..63 cyclically, sent back-to-back with no idle bits → exactly 256 `we` pulses. `wr_count` wraps to 0. Every `waddr` and `wdata` matches the stimulus.
